// File: rtl/rv_core_pkg.sv
// Shared core-wide widths and the register-file write record used by the
// writeback arbiter and its divider result buffer.
package rv_core_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } rf_wr_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with the whole entry array and a per-slot valid
// vector exposed so the owner can scan buffered contents.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic                             push,
   input  logic [WIDTH-1:0]                 push_data,
   input  logic                             pop,
   output logic [WIDTH-1:0]                 head,
   output logic                             full,
   output logic                             empty,
   output logic [$clog2(DEPTH+1)-1:0]       count,
   output logic [DEPTH-1:0][WIDTH-1:0]      entries,
   output logic [DEPTH-1:0]                 entry_valid
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [PTR_W-1:0]            wr_ptr;
   logic [PTR_W-1:0]            rd_ptr;
   logic [PTR_W-1:0]            offset;
   logic                        do_push;
   logic                        do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];
   assign entries = mem;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: slots are only observed through entry_valid.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // A slot is live when its distance from the read pointer (mod DEPTH) is below count.
   always_comb begin
      offset      = '0;
      entry_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset         = PTR_W'(i) - rd_ptr;
         entry_valid[i] = ({1'b0, offset} < count);
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between writeback and buffered divider
// results, forcing a one-cycle writeback stall when the buffer head starves.
module regfile_wb_arbiter
   import rv_core_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_addr_rd,
   input  logic [XLEN-1:0]       wb_data_rd,
   input  logic                  div_valid,
   output logic                  div_ready,
   input  logic [REG_ADDR_W-1:0] div_addr_rd,
   input  logic [XLEN-1:0]       div_data_rd,
   output logic                  wb_stall,
   output logic                  rf_write_enable,
   output logic [REG_ADDR_W-1:0] rf_addr_rd,
   output logic [XLEN-1:0]       rf_data_rd,
   output logic [XLEN-1:0]       pending_mask
);

   localparam int WAIT_W = $clog2(MAX_WAIT+1);
   localparam int CNT_W  = $clog2(DEPTH+1);
   localparam int ENT_W  = $bits(rf_wr_t);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

   rf_wr_t                      push_entry;
   rf_wr_t                      head;
   rf_wr_t                      scan_entry;
   logic [ENT_W-1:0]            head_bits;
   logic [DEPTH-1:0][ENT_W-1:0] entries;
   logic [DEPTH-1:0]            entry_valid;
   logic [CNT_W-1:0]            fifo_count;
   logic                        unused_count;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic                        push;
   logic                        pop;
   logic                        wb_real;
   logic                        force_grant;
   logic [WAIT_W-1:0]           wait_cnt;

   assign push_entry   = '{addr: div_addr_rd, data: div_data_rd};
   assign head         = head_bits;
   assign unused_count = ^fifo_count;

   // Writes to x0 are dropped on both sides; holding reset_n low blocks every grant.
   assign div_ready   = reset_n && !fifo_full;
   assign push        = div_valid && div_ready && (div_addr_rd != '0);
   assign wb_real     = reset_n && wb_we && (wb_addr_rd != '0);
   assign force_grant = !fifo_empty && (wait_cnt == WAIT_LIMIT);

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clock       (clock),
      .reset_n     (reset_n),
      .push        (push),
      .push_data   (push_entry),
      .pop         (pop),
      .head        (head_bits),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .count       (fifo_count),
      .entries     (entries),
      .entry_valid (entry_valid)
   );

   always_comb begin
      rf_write_enable = 1'b0;
      rf_addr_rd      = '0;
      rf_data_rd      = '0;
      wb_stall        = 1'b0;
      pop             = 1'b0;
      if (force_grant) begin
         pop             = 1'b1;
         wb_stall        = 1'b1;
         rf_write_enable = 1'b1;
         rf_addr_rd      = head.addr;
         rf_data_rd      = head.data;
      end else if (wb_real) begin
         rf_write_enable = 1'b1;
         rf_addr_rd      = wb_addr_rd;
         rf_data_rd      = wb_data_rd;
      end else if (!fifo_empty) begin
         pop             = 1'b1;
         rf_write_enable = 1'b1;
         rf_addr_rd      = head.addr;
         rf_data_rd      = head.data;
      end
   end

   // Counts how long the current head has gone without a grant.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= '0;
      end else if (fifo_empty || pop) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_LIMIT) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   always_comb begin
      scan_entry   = '0;
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_entry = entries[i];
         if (entry_valid[i]) pending_mask[scan_entry.addr] = 1'b1;
      end
      pending_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change just after the falling
// edge and outputs are compared 1 time unit later, well clear of the rising edge.
module tb_regfile_wb_arbiter;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        wb_we;
   logic [4:0]  wb_addr_rd;
   logic [31:0] wb_data_rd;
   logic        div_valid;
   logic        div_ready;
   logic [4:0]  div_addr_rd;
   logic [31:0] div_data_rd;
   logic        wb_stall;
   logic        rf_write_enable;
   logic [4:0]  rf_addr_rd;
   logic [31:0] rf_data_rd;
   logic [31:0] pending_mask;

   int          checks = 0;
   int          passed = 0;
   logic [31:0] x7_value;

   regfile_wb_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .wb_we           (wb_we),
      .wb_addr_rd      (wb_addr_rd),
      .wb_data_rd      (wb_data_rd),
      .div_valid       (div_valid),
      .div_ready       (div_ready),
      .div_addr_rd     (div_addr_rd),
      .div_data_rd     (div_data_rd),
      .wb_stall        (wb_stall),
      .rf_write_enable (rf_write_enable),
      .rf_addr_rd      (rf_addr_rd),
      .rf_data_rd      (rf_data_rd),
      .pending_mask    (pending_mask)
   );

   always #5 clock = ~clock;

   task automatic set_idle();
      wb_we       = 1'b0;
      wb_addr_rd  = '0;
      wb_data_rd  = '0;
      div_valid   = 1'b0;
      div_addr_rd = '0;
      div_data_rd = '0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      set_idle();
      #2;
      checks++;
      if ({div_ready, rf_write_enable, wb_stall} !== 3'b000)
         $display("[TB] FAIL reset_outputs: got ready/we/stall=%b want 000", {div_ready, rf_write_enable, wb_stall});
      else passed++;
      checks++;
      if (pending_mask !== 32'h0)
         $display("[TB] FAIL reset_mask: got %h want 00000000", pending_mask);
      else passed++;
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      checks++;
      if ({div_ready, rf_write_enable} !== 2'b10)
         $display("[TB] FAIL reset_release: got ready/we=%b want 10", {div_ready, rf_write_enable});
      else passed++;
      @(negedge clock);
   endtask

   task automatic test_idle_drain();
      div_valid = 1'b1; div_addr_rd = 5'd5; div_data_rd = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({div_ready, rf_write_enable} !== 2'b10)
         $display("[TB] FAIL drain_no_bypass: got ready/we=%b want 10", {div_ready, rf_write_enable});
      else passed++;
      @(negedge clock);
      set_idle();
      #1;
      checks++;
      if ({rf_write_enable, wb_stall, rf_addr_rd, rf_data_rd} !== {1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF})
         $display("[TB] FAIL drain_write: got we=%b stall=%b addr=%0d data=%h want 1 0 5 deadbeef",
                  rf_write_enable, wb_stall, rf_addr_rd, rf_data_rd);
      else passed++;
      checks++;
      if (pending_mask !== 32'h0000_0020)
         $display("[TB] FAIL drain_mask_set: got %h want 00000020", pending_mask);
      else passed++;
      @(negedge clock);
      #1;
      checks++;
      if ({rf_write_enable, pending_mask} !== {1'b0, 32'h0})
         $display("[TB] FAIL drain_after: got we=%b mask=%h want 0 00000000", rf_write_enable, pending_mask);
      else passed++;
      @(negedge clock);
   endtask

   task automatic test_x0();
      wb_we = 1'b1; wb_addr_rd = 5'd0; wb_data_rd = 32'hBAD0_0000;
      div_valid = 1'b1; div_addr_rd = 5'd9; div_data_rd = 32'h0000_0099;
      #1;
      checks++;
      if (rf_write_enable !== 1'b0)
         $display("[TB] FAIL x0_wb_not_write: got we=%b want 0", rf_write_enable);
      else passed++;
      @(negedge clock);
      div_valid = 1'b0;
      #1;
      checks++;
      if ({rf_write_enable, wb_stall, rf_addr_rd, rf_data_rd} !== {1'b1, 1'b0, 5'd9, 32'h0000_0099})
         $display("[TB] FAIL x0_head_granted: got we=%b stall=%b addr=%0d data=%h want 1 0 9 00000099",
                  rf_write_enable, wb_stall, rf_addr_rd, rf_data_rd);
      else passed++;
      @(negedge clock);
      wb_we = 1'b0;
      div_valid = 1'b1; div_addr_rd = 5'd0; div_data_rd = 32'hFFFF_FFFF;
      #1;
      checks++;
      if ({div_ready, rf_write_enable} !== 2'b10)
         $display("[TB] FAIL x0_div_accept: got ready/we=%b want 10", {div_ready, rf_write_enable});
      else passed++;
      @(negedge clock);
      set_idle();
      #1;
      checks++;
      if ({rf_write_enable, pending_mask} !== {1'b0, 32'h0})
         $display("[TB] FAIL x0_div_dropped: got we=%b mask=%h want 0 00000000", rf_write_enable, pending_mask);
      else passed++;
      @(negedge clock);
   endtask

   task automatic test_starvation();
      logic [31:0] exp_data;
      wb_we = 1'b1; wb_addr_rd = 5'd3; wb_data_rd = 32'h3000_0000;
      div_valid = 1'b1; div_addr_rd = 5'd10; div_data_rd = 32'hAAAA_0010;
      @(negedge clock);
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 1; k <= 8; k++) begin
            if (pass == 0 && k == 1) begin
               div_valid = 1'b1; div_addr_rd = 5'd11; div_data_rd = 32'hBBBB_0011;
            end else begin
               div_valid = 1'b0;
            end
            exp_data   = 32'h3000_0000 + 32'(pass * 16 + k);
            wb_data_rd = exp_data;
            #1;
            checks++;
            if ({rf_write_enable, wb_stall, rf_addr_rd, rf_data_rd} !== {1'b1, 1'b0, 5'd3, exp_data})
               $display("[TB] FAIL starve_wb_%0d_%0d: got we=%b stall=%b addr=%0d data=%h want 1 0 3 %h",
                        pass, k, rf_write_enable, wb_stall, rf_addr_rd, rf_data_rd, exp_data);
            else passed++;
            @(negedge clock);
         end
         #1;
         checks++;
         if (pass == 0) begin
            if ({rf_write_enable, wb_stall, rf_addr_rd, rf_data_rd} !== {1'b1, 1'b1, 5'd10, 32'hAAAA_0010})
               $display("[TB] FAIL starve_force_x10: got we=%b stall=%b addr=%0d data=%h want 1 1 10 aaaa0010",
                        rf_write_enable, wb_stall, rf_addr_rd, rf_data_rd);
            else passed++;
         end else begin
            if ({rf_write_enable, wb_stall, rf_addr_rd, rf_data_rd} !== {1'b1, 1'b1, 5'd11, 32'hBBBB_0011})
               $display("[TB] FAIL starve_force_x11: got we=%b stall=%b addr=%0d data=%h want 1 1 11 bbbb0011",
                        rf_write_enable, wb_stall, rf_addr_rd, rf_data_rd);
            else passed++;
         end
         @(negedge clock);
      end
      #1;
      checks++;
      if ({wb_stall, rf_addr_rd, pending_mask} !== {1'b0, 5'd3, 32'h0})
         $display("[TB] FAIL starve_done: got stall=%b addr=%0d mask=%h want 0 3 00000000",
                  wb_stall, rf_addr_rd, pending_mask);
      else passed++;
      set_idle();
      @(negedge clock);
   endtask

   task automatic test_full();
      wb_we = 1'b1; wb_addr_rd = 5'd20;
      for (int k = 0; k < 4; k++) begin
         div_valid = 1'b1; div_addr_rd = 5'(k + 1); div_data_rd = 32'h11 * 32'(k + 1);
         wb_data_rd = 32'hA000_0000 + 32'(k);
         #1;
         checks++;
         if ({div_ready, rf_write_enable, wb_stall, rf_addr_rd} !== {1'b1, 1'b1, 1'b0, 5'd20})
            $display("[TB] FAIL full_fill_%0d: got ready=%b we=%b stall=%b addr=%0d want 1 1 0 20",
                     k, div_ready, rf_write_enable, wb_stall, rf_addr_rd);
         else passed++;
         @(negedge clock);
      end
      div_valid = 1'b0;
      #1;
      checks++;
      if (pending_mask !== 32'h0000_001E)
         $display("[TB] FAIL full_mask: got %h want 0000001e", pending_mask);
      else passed++;
      for (int k = 4; k <= 8; k++) begin
         #1;
         checks++;
         if ({div_ready, rf_write_enable, wb_stall, rf_addr_rd} !== {1'b0, 1'b1, 1'b0, 5'd20})
            $display("[TB] FAIL full_blocked_%0d: got ready=%b we=%b stall=%b addr=%0d want 0 1 0 20",
                     k, div_ready, rf_write_enable, wb_stall, rf_addr_rd);
         else passed++;
         @(negedge clock);
      end
      #1;
      checks++;
      if ({div_ready, wb_stall, rf_addr_rd, rf_data_rd} !== {1'b0, 1'b1, 5'd1, 32'h11})
         $display("[TB] FAIL full_force_x1: got ready=%b stall=%b addr=%0d data=%h want 0 1 1 00000011",
                  div_ready, wb_stall, rf_addr_rd, rf_data_rd);
      else passed++;
      @(negedge clock);
      wb_we = 1'b0;
      div_valid = 1'b1; div_addr_rd = 5'd6; div_data_rd = 32'h66;
      #1;
      checks++;
      if ({div_ready, rf_write_enable, wb_stall, rf_addr_rd, rf_data_rd} !== {1'b1, 1'b1, 1'b0, 5'd2, 32'h22})
         $display("[TB] FAIL full_push_pop: got ready=%b we=%b stall=%b addr=%0d data=%h want 1 1 0 2 00000022",
                  div_ready, rf_write_enable, wb_stall, rf_addr_rd, rf_data_rd);
      else passed++;
      @(negedge clock);
      div_valid = 1'b0;
      #1;
      checks++;
      if ({div_ready, rf_addr_rd, rf_data_rd, pending_mask} !== {1'b1, 5'd3, 32'h33, 32'h0000_0058})
         $display("[TB] FAIL full_count3: got ready=%b addr=%0d data=%h mask=%h want 1 3 00000033 00000058",
                  div_ready, rf_addr_rd, rf_data_rd, pending_mask);
      else passed++;
      @(negedge clock);
      #1;
      checks++;
      if ({rf_write_enable, rf_addr_rd, rf_data_rd} !== {1'b1, 5'd4, 32'h44})
         $display("[TB] FAIL full_drain_x4: got we=%b addr=%0d data=%h want 1 4 00000044",
                  rf_write_enable, rf_addr_rd, rf_data_rd);
      else passed++;
      @(negedge clock);
      #1;
      checks++;
      if ({rf_write_enable, rf_addr_rd, rf_data_rd} !== {1'b1, 5'd6, 32'h66})
         $display("[TB] FAIL full_drain_x6: got we=%b addr=%0d data=%h want 1 6 00000066",
                  rf_write_enable, rf_addr_rd, rf_data_rd);
      else passed++;
      @(negedge clock);
      #1;
      checks++;
      if ({rf_write_enable, pending_mask} !== {1'b0, 32'h0})
         $display("[TB] FAIL full_empty: got we=%b mask=%h want 0 00000000", rf_write_enable, pending_mask);
      else passed++;
      set_idle();
      @(negedge clock);
   endtask

   task automatic test_same_dest();
      x7_value = 32'hFFFF_FFFF;
      div_valid = 1'b1; div_addr_rd = 5'd7; div_data_rd = 32'd1;
      #1;
      checks++;
      if (rf_write_enable !== 1'b0)
         $display("[TB] FAIL dup_no_bypass: got we=%b want 0", rf_write_enable);
      else passed++;
      @(negedge clock);
      div_data_rd = 32'd2;
      #1;
      if (rf_write_enable && rf_addr_rd == 5'd7) x7_value = rf_data_rd;
      checks++;
      if ({rf_write_enable, rf_addr_rd, rf_data_rd, pending_mask} !== {1'b1, 5'd7, 32'd1, 32'h80})
         $display("[TB] FAIL dup_first: got we=%b addr=%0d data=%h mask=%h want 1 7 00000001 00000080",
                  rf_write_enable, rf_addr_rd, rf_data_rd, pending_mask);
      else passed++;
      @(negedge clock);
      div_valid = 1'b0;
      #1;
      if (rf_write_enable && rf_addr_rd == 5'd7) x7_value = rf_data_rd;
      checks++;
      if ({rf_write_enable, rf_addr_rd, rf_data_rd, pending_mask} !== {1'b1, 5'd7, 32'd2, 32'h80})
         $display("[TB] FAIL dup_second: got we=%b addr=%0d data=%h mask=%h want 1 7 00000002 00000080",
                  rf_write_enable, rf_addr_rd, rf_data_rd, pending_mask);
      else passed++;
      @(negedge clock);
      #1;
      checks++;
      if ({rf_write_enable, pending_mask, x7_value} !== {1'b0, 32'h0, 32'd2})
         $display("[TB] FAIL dup_final: got we=%b mask=%h x7=%h want 0 00000000 00000002",
                  rf_write_enable, pending_mask, x7_value);
      else passed++;
      @(negedge clock);
   endtask

   task automatic test_reset_midstream();
      wb_we = 1'b1; wb_addr_rd = 5'd15; wb_data_rd = 32'h1515_1515;
      div_valid = 1'b1; div_addr_rd = 5'd12; div_data_rd = 32'hC;
      @(negedge clock);
      div_addr_rd = 5'd13; div_data_rd = 32'hD;
      @(negedge clock);
      set_idle();
      #1;
      checks++;
      if (pending_mask !== 32'h0000_3000)
         $display("[TB] FAIL midreset_before: got mask=%h want 00003000", pending_mask);
      else passed++;
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({div_ready, rf_write_enable, wb_stall, pending_mask} !== {3'b000, 32'h0})
         $display("[TB] FAIL midreset_immediate: got ready=%b we=%b stall=%b mask=%h want 0 0 0 00000000",
                  div_ready, rf_write_enable, wb_stall, pending_mask);
      else passed++;
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      checks++;
      if ({div_ready, rf_write_enable, pending_mask} !== {2'b10, 32'h0})
         $display("[TB] FAIL midreset_after: got ready=%b we=%b mask=%h want 1 0 00000000",
                  div_ready, rf_write_enable, pending_mask);
      else passed++;
      @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_idle_drain();
      test_x0();
      test_starvation();
      test_full();
      test_same_dest();
      test_reset_midstream();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
